alu_op_sequencer: RTL and testbench

- Handshaked front-end controller for the shared 32-bit signed ALU function set (add, sub, mul, div, mod, and, or, with flags Z/N/V/C).
- Accepts one operation at a time on a valid/ready request port and returns the result and flags on a valid/ready response port.
- Single-cycle ops complete in 1 cycle. Mul, div and mod run on an internal iterative shift-add / restoring-divide engine of WIDTH steps.
- Sits between the decode/issue logic and the register write-back path.

---
 rtl/alu_op_sequencer.sv | 133 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: valid/ready front-end for the signed ALU op set, iterative mul/div/mod engine
module alu_op_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_z,
   output logic             rsp_n,
   output logic             rsp_v,
   output logic             rsp_c,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
   localparam int CW = $clog2(WIDTH);
   localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_MUL = 4'b0010, OP_DIV = 4'b0011,
                          OP_MOD = 4'b0100, OP_AND = 4'b1000, OP_OR = 4'b1001;
   state_t state;
   logic [3:0] op;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] hi, lo, dvs;
   logic neg;
   logic [WIDTH:0] add_w, sub_w, m_sum, d_sh;
   logic [WIDTH-1:0] abs_a, abs_b, q_res, d_sub, quo, rem, f_res;
   logic [2*WIDTH-1:0] prod;
   logic q_v, q_c, iter_go, d_ge, f_v;
   assign req_ready = state == IDLE;
   assign rsp_valid = state == DONE;
   assign busy = state != IDLE;
   always_comb begin
      add_w = {1'b0, req_a} + {1'b0, req_b};
      sub_w = {1'b0, req_a} - {1'b0, req_b};
      abs_a = req_a[WIDTH-1] ? -req_a : req_a;
      abs_b = req_b[WIDTH-1] ? -req_b : req_b;
      iter_go = req_op == OP_MUL || ((req_op == OP_DIV || req_op == OP_MOD) && req_b != '0);
      q_res = '0;
      q_v = 1'b0;
      q_c = 1'b0;
      case (req_op)
         OP_ADD: begin
            q_res = add_w[WIDTH-1:0];
            q_c = add_w[WIDTH];
            q_v = (req_a[WIDTH-1] == req_b[WIDTH-1]) && (add_w[WIDTH-1] != req_a[WIDTH-1]);
         end
         OP_SUB: begin
            q_res = sub_w[WIDTH-1:0];
            q_c = sub_w[WIDTH];
            q_v = (req_a[WIDTH-1] != req_b[WIDTH-1]) && (sub_w[WIDTH-1] != req_a[WIDTH-1]);
         end
         OP_AND: q_res = req_a & req_b;
         OP_OR: q_res = req_a | req_b;
         default: q_res = '0;
      endcase
   end
   // one engine step: shift-add uses {hi,lo} as product/multiplier, restoring divide uses hi=remainder, lo=quotient
   always_comb begin
      m_sum = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
      d_sh = {hi, lo[WIDTH-1]};
      d_ge = d_sh >= {1'b0, dvs};
      d_sub = d_sh[WIDTH-1:0] - dvs;
      prod = neg ? -{hi, lo} : {hi, lo};
      quo = neg ? -lo : lo;
      rem = neg ? -hi : hi;
      f_res = op == OP_MUL ? prod[WIDTH-1:0] : op == OP_DIV ? quo : rem;
      f_v = op == OP_MUL ? !(&prod[2*WIDTH-1:WIDTH-1] || ~|prod[2*WIDTH-1:WIDTH-1])
                         : op == OP_DIV && !neg && lo[WIDTH-1];
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         op <= '0;
         cnt <= '0;
         hi <= '0;
         lo <= '0;
         dvs <= '0;
         neg <= 1'b0;
         rsp_result <= '0;
         rsp_z <= 1'b0;
         rsp_n <= 1'b0;
         rsp_v <= 1'b0;
         rsp_c <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               op <= req_op;
               if (iter_go) begin
                  hi <= '0;
                  lo <= req_op == OP_MUL ? abs_b : abs_a;
                  dvs <= req_op == OP_MUL ? abs_a : abs_b;
                  neg <= req_a[WIDTH-1] ^ (req_op != OP_MOD && req_b[WIDTH-1]);
                  cnt <= CW'(WIDTH - 1);
                  state <= ITER;
               end else begin
                  rsp_result <= q_res;
                  rsp_z <= q_res == '0;
                  rsp_n <= q_res[WIDTH-1];
                  rsp_v <= q_v;
                  rsp_c <= q_c;
                  state <= DONE;
               end
            end
            ITER: begin
               if (op == OP_MUL) begin
                  hi <= m_sum[WIDTH:1];
                  lo <= {m_sum[0], lo[WIDTH-1:1]};
               end else begin
                  hi <= d_ge ? d_sub : d_sh[WIDTH-1:0];
                  lo <= {lo[WIDTH-2:0], d_ge};
               end
               if (cnt == '0) state <= FIX;
               else cnt <= cnt - 1'b1;
            end
            FIX: begin
               rsp_result <= f_res;
               rsp_z <= f_res == '0;
               rsp_n <= f_res[WIDTH-1];
               rsp_v <= f_v;
               rsp_c <= 1'b0;
               state <= DONE;
            end
            DONE: if (rsp_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed vector table, corner sequences and randomized ops vs. a reference model
module tb_alu_op_sequencer;
   logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, rsp_ready = 1'b1;
   logic req_ready, rsp_valid, rsp_z, rsp_n, rsp_v, rsp_c, busy;
   logic [3:0] req_op = '0;
   logic [31:0] req_a = '0, req_b = '0, rsp_result;
   int n_chk = 0, n_fail = 0;
   typedef struct {
      logic [3:0] op;
      logic [31:0] a, b, res;
      logic [3:0] f;
      int lat;
   } vec_t;
   typedef struct {
      logic [31:0] res;
      logic [3:0] f;
   } exp_t;
   vec_t tbl[16];
   alu_op_sequencer #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_z(rsp_z), .rsp_n(rsp_n), .rsp_v(rsp_v), .rsp_c(rsp_c), .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask
   function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, b, res, input logic [3:0] f, input int lat);
      mk.op = op; mk.a = a; mk.b = b; mk.res = res; mk.f = f; mk.lat = lat;
   endfunction
   // plain 64-bit integer arithmetic; flags packed {z,n,v,c}
   function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, b);
      longint sa = longint'(signed'(a)), sb = longint'(signed'(b));
      longint ua = longint'({32'h0, a}), ub = longint'({32'h0, b});
      longint full = 0;
      logic v = 1'b0, c = 1'b0;
      case (op)
         4'd0: begin full = sa + sb; c = (ua + ub) > 64'hFFFF_FFFF; end
         4'd1: begin full = sa - sb; c = ua < ub; end
         4'd2: full = sa * sb;
         4'd3: full = sb == 0 ? 0 : sa / sb;
         4'd4: full = sb == 0 ? 0 : sa % sb;
         4'd8: full = longint'(signed'(a & b));
         4'd9: full = longint'(signed'(a | b));
         default: full = 0;
      endcase
      if (op <= 4'd3) v = full > 64'sd2147483647 || full < -64'sd2147483648;
      model.res = full[31:0];
      model.f = {model.res == 0, model.res[31], v, c};
   endfunction
   task automatic run_op(input logic [3:0] o, input logic [31:0] a, b, output logic [31:0] r, output logic [3:0] f, output int lat);
      req_op = o; req_a = a; req_b = b; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; req_a = $urandom; req_b = $urandom; req_op = 4'($urandom);
      lat = 1;
      while (!rsp_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      r = rsp_result;
      f = {rsp_z, rsp_n, rsp_v, rsp_c};
      @(posedge clk); #1;
   endtask
   initial begin
      logic [31:0] r, a, b;
      logic [3:0] f, o;
      int lat, seen;
      exp_t e;
      logic [3:0] ops[8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9, 4'd6};
      logic [31:0] spec_vals[5] = '{32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h1};
      tbl[0]  = mk(4'd0, 32'd5, 32'd10, 32'd15, 4'b0000, 1);
      tbl[1]  = mk(4'd1, 32'd10, 32'd5, 32'd5, 4'b0000, 1);
      tbl[2]  = mk(4'd1, 32'd3, 32'd5, 32'hFFFF_FFFE, 4'b0101, 1);
      tbl[3]  = mk(4'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b0110, 1);
      tbl[4]  = mk(4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b1001, 1);
      tbl[5]  = mk(4'd2, 32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFF4, 4'b0100, 34);
      tbl[6]  = mk(4'd2, 32'h0001_0000, 32'h0001_0000, 32'd0, 4'b1010, 34);
      tbl[7]  = mk(4'd3, 32'hFFFF_FFF3, 32'd5, 32'hFFFF_FFFE, 4'b0100, 34);
      tbl[8]  = mk(4'd4, 32'hFFFF_FFF3, 32'd5, 32'hFFFF_FFFD, 4'b0100, 34);
      tbl[9]  = mk(4'd4, 32'd13, 32'd5, 32'd3, 4'b0000, 34);
      tbl[10] = mk(4'd3, 32'd8, 32'd0, 32'd0, 4'b1000, 1);
      tbl[11] = mk(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 4'b0110, 34);
      tbl[12] = mk(4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 4'b1000, 34);
      tbl[13] = mk(4'hF, 32'd1, 32'd2, 32'd0, 4'b1000, 1);
      tbl[14] = mk(4'd8, 32'hF0, 32'h3C, 32'h30, 4'b0000, 1);
      tbl[15] = mk(4'd2, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd1, 4'b0010, 34);
      repeat (3) @(posedge clk);
      #1;
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_result", rsp_result, 0);
      check("reset_flags", {rsp_z, rsp_n, rsp_v, rsp_c}, 0);
      check("reset_busy", busy, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("reset_req_ready", req_ready, 1);
      foreach (tbl[i]) begin
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, r, f, lat);
         check($sformatf("vec%0d_result", i), r, tbl[i].res);
         check($sformatf("vec%0d_flags", i), f, tbl[i].f);
         check($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
      end
      rsp_ready = 1'b0;
      req_op = 4'd8; req_a = 32'd1; req_b = 32'd1; req_valid = 1'b1;
      @(posedge clk); #1;
      req_op = 4'd0; req_a = 32'd5; req_b = 32'd5;
      for (int i = 0; i < 5; i++) begin
         check("bp_rsp_valid", rsp_valid, 1);
         check("bp_result", rsp_result, 1);
         check("bp_req_ready", req_ready, 0);
         check("bp_busy", busy, 1);
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_rsp_valid", rsp_valid, 0);
      check("bp_release_req_ready", req_ready, 1);
      check("bp_release_busy", busy, 0);
      req_op = 4'd2; req_a = 32'd7; req_b = 32'd9; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("midit_busy", busy, 1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("midit_rsp_valid", rsp_valid, 0);
      check("midit_result", rsp_result, 0);
      check("midit_flags", {rsp_z, rsp_n, rsp_v, rsp_c}, 0);
      check("midit_req_ready", req_ready, 1);
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (rsp_valid) seen++;
      end
      check("midit_no_response", seen, 0);
      run_op(4'd9, 32'd0, 32'd1, r, f, lat);
      check("post_reset_or", r, 1);
      check("post_reset_or_lat", lat, 1);
      for (int i = 0; i < 60; i++) begin
         o = ops[$urandom_range(0, 7)];
         if (o == 4'd6) o = 4'($urandom_range(10, 15));
         a = $urandom_range(0, 3) == 0 ? spec_vals[$urandom_range(0, 4)] : $urandom;
         b = $urandom_range(0, 3) == 0 ? spec_vals[$urandom_range(0, 4)] : $urandom;
         if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 15)) - 32'd8;
         e = model(o, a, b);
         run_op(o, a, b, r, f, lat);
         check($sformatf("rnd%0d_op%0d_result", i, o), r, e.res);
         check($sformatf("rnd%0d_op%0d_flags", i, o), f, e.f);
         check($sformatf("rnd%0d_op%0d_latency", i, o), lat,
               (o == 4'd2 || ((o == 4'd3 || o == 4'd4) && b != 0)) ? 34 : 1);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
